// File: rtl/ram_sp.sv
// ram_sp -- single-port synchronous RAM, one byte lane of a wide simulation memory.
//
// One read/write port with registered read data. Reads are read-first: on a
// same-address write the output returns the old word and the new word shows
// up on the following read. The storage array is deliberately left
// un-reset and un-initialised, and is kept at a fixed hierarchical name so
// a parent memory or a testbench can preload and peek it by index.
//
// Parameters
//   DATAWIDTH         word width in bits (positional #1)
//   ADDRWIDTH         address width; depth is 2**ADDRWIDTH words (positional #2)
//
// Ports
//   PortAClk          in   clock; all state changes on the rising edge
//   PortARstN         in   asynchronous active-low reset (clears read data only)
//   PortAAddr         in   word address, sampled every rising edge
//   PortADataIn       in   write data
//   PortAWriteEnable  in   1 = write PortADataIn to PortAAddr on this edge
//   PortADataOut      out  registered read data, one cycle after the address

module ram_sp #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 21
) (
    input  logic                 PortAClk,
    input  logic                 PortARstN,
    input  logic [ADDRWIDTH-1:0] PortAAddr,
    input  logic [DATAWIDTH-1:0] PortADataIn,
    input  logic                 PortAWriteEnable,
    output logic [DATAWIDTH-1:0] PortADataOut
);

    localparam int unsigned Depth = 1 << ADDRWIDTH;

    // Name and indexing are relied on by backdoor loaders; keep them stable.
    logic [DATAWIDTH-1:0] ram_mem [0:Depth-1];

    logic                 write_en;
    logic [DATAWIDTH-1:0] rd_data_q;

    // An X on the enable evaluates false here, so an unknown enable never
    // corrupts the array; the assertion below flags it.
    assign write_en = PortARstN && (PortAWriteEnable == 1'b1);

    // No reset on the array: contents persist through reset.
    always_ff @(posedge PortAClk) begin
        if (write_en) begin
            ram_mem[PortAAddr] <= PortADataIn;
        end
    end

    // Read-first falls out of the non-blocking update: this edge samples the
    // word before the write above lands.
    always_ff @(posedge PortAClk or negedge PortARstN) begin
        if (!PortARstN) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= ram_mem[PortAAddr];
        end
    end

    assign PortADataOut = rd_data_q;

    // Simulation-only guard against an unknown write enable.
    we_known_a: assert property (@(posedge PortAClk) disable iff (!PortARstN)
                                 !$isunknown(PortAWriteEnable))
        else $warning("ram_sp: X on PortAWriteEnable, write suppressed");

endmodule

// File: tb/tb_ram_sp.sv
// tb_ram_sp -- directed self-checking bench for ram_sp.
//
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same offset, well away from the next edge.

module tb_ram_sp;

    localparam int DW = 8;
    localparam int AW = 16;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          we;
    logic [DW-1:0] dout;

    int checks = 0;
    int errors = 0;

    ram_sp #(
        .DATAWIDTH(DW),
        .ADDRWIDTH(AW)
    ) dut (
        .PortAClk        (clk),
        .PortARstN       (rst_n),
        .PortAAddr       (addr),
        .PortADataIn     (din),
        .PortAWriteEnable(we),
        .PortADataOut    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        addr = a;
        we   = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = '0;
        din   = '0;
        we    = 1'b0;
        #2;
        check("reset_out", dout, 8'h00);
        tick();
        tick();
        check("reset_out_edges", dout, 8'h00);
        rst_n = 1'b1;

        // Basic write then read.
        wr(16'd3, 8'hA5);
        rd(16'd3);
        check("wr_rd_addr3", dout, 8'hA5);

        // Read-first on same-address write.
        wr(16'd7, 8'h11);
        addr = 16'd7;
        din  = 8'h22;
        we   = 1'b1;
        tick();
        check("rdw_old", dout, 8'h11);
        rd(16'd7);
        check("rdw_new", dout, 8'h22);

        // Address boundaries, plus a word that would alias if the top bit were lost.
        wr(16'h7FFF, 8'h77);
        wr(16'h0000, 8'hFF);
        wr(16'hFFFF, 8'h01);
        rd(16'h0000);
        check("bound_lo", dout, 8'hFF);
        rd(16'hFFFF);
        check("bound_hi", dout, 8'h01);
        rd(16'h7FFF);
        check("no_alias", dout, 8'h77);

        // Backdoor preload visible to the next clocked read.
        dut.ram_mem[16'h4000] = 8'h3C;
        rd(16'h4000);
        check("backdoor", dout, 8'h3C);

        // Mid-run reset: output clears without an edge, writes are ignored.
        wr(16'd9, 8'h5A);
        rd(16'd9);
        check("pre_reset", dout, 8'h5A);
        rst_n = 1'b0;
        #1;
        check("async_clear", dout, 8'h00);
        addr = 16'd9;
        din  = 8'hEE;
        we   = 1'b1;
        tick();
        check("reset_hold1", dout, 8'h00);
        tick();
        check("reset_hold2", dout, 8'h00);
        we    = 1'b0;
        rst_n = 1'b1;
        rd(16'd9);
        check("write_in_reset_ignored", dout, 8'h5A);
        rd(16'h4000);
        check("backdoor_survives_reset", dout, 8'h3C);

        // Hold: constant address, output constant; new address lands after one edge.
        addr = 16'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold_%0d", i), dout, 8'hA5);
        end
        addr = 16'd7;
        #2;
        check("addr_change_pre_edge", dout, 8'hA5);
        tick();
        check("addr_change_post_edge", dout, 8'h22);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
